// File: rtl/chan_send_arbiter_if.sv
// Grant handshake between the channel send arbiter (master) and the packet sender (slave),
// together with the per-channel FIFO non-empty flags feeding arbitration.
interface chan_send_arbiter_if #(
    parameter int CHANNEL_BIT = 1
);
    localparam int CHANNEL = 1 << CHANNEL_BIT;

    logic [CHANNEL-1:0]     req;
    logic                   grant_valid;
    logic [CHANNEL_BIT-1:0] grant_chan;
    logic                   grant_take;

    modport master (
        input  req,
        input  grant_take,
        output grant_valid,
        output grant_chan
    );

    modport slave (
        output req,
        output grant_take,
        input  grant_valid,
        input  grant_chan
    );
endinterface

// File: rtl/chan_send_arbiter.sv
// Priority/aging scheduler sharing one serial send path among the outbound channel FIFOs.
// Offers one grant at a time; skipped channels age and get promoted up to PRIO_MAX.
module chan_send_arbiter #(
    parameter int                                CHANNEL_BIT      = 1,
    parameter logic [5*(1<<CHANNEL_BIT)-1:0]     CHANNEL_PRIORITY = {(1 << CHANNEL_BIT){5'd8}},
    parameter int                                AGE_LIMIT        = 7,
    parameter int                                PRIO_MAX         = 15
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    chan_send_arbiter_if.master             bus,
    input  logic                            cfg_we_i,
    input  logic [CHANNEL_BIT-1:0]          cfg_chan_i,
    input  logic [4:0]                      cfg_prio_i,
    output logic [5*(1<<CHANNEL_BIT)-1:0]   cur_prio_o
);
    localparam int         CHANNEL     = 1 << CHANNEL_BIT;
    localparam logic [2:0] AGE_LIMIT_C = 3'(AGE_LIMIT);
    localparam logic [4:0] PRIO_MAX_C  = 5'(PRIO_MAX);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        OFFER = 2'd1,
        COOL  = 2'd2
    } state_e;

    state_e                 state_q;
    logic                   grant_valid_q;
    logic [CHANNEL_BIT-1:0] grant_chan_q;
    logic [4:0]             base_q [CHANNEL];
    logic [4:0]             prio_q [CHANNEL];
    logic [2:0]             age_q  [CHANNEL];
    logic [4:0]             base_d [CHANNEL];
    logic [4:0]             prio_d [CHANNEL];
    logic [2:0]             age_d  [CHANNEL];

    logic                   win_found_s;
    logic [CHANNEL_BIT-1:0] win_chan_s;
    logic [4:0]             win_prio_s;
    logic [2:0]             win_age_s;
    logic                   better_s;
    logic                   take_s;

    // Saturating promotion; a priority already at or above the ceiling is left alone.
    function automatic logic [4:0] promote(input logic [4:0] p);
        logic [4:0] r;
        if (p >= PRIO_MAX_C) begin
            r = p;
        end else begin
            r = p + 5'd1;
        end
        return r;
    endfunction

    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_chan  = grant_chan_q;
    assign take_s          = (state_q == OFFER) && bus.grant_take;

    // Winner: highest priority, then oldest age, then lowest index (strict compare keeps lowest).
    always_comb begin
        win_found_s = 1'b0;
        win_chan_s  = '0;
        win_prio_s  = 5'd0;
        win_age_s   = 3'd0;
        better_s    = 1'b0;
        for (int j = 0; j < CHANNEL; j++) begin
            better_s    = bus.req[j] && (!win_found_s || (prio_q[j] > win_prio_s) ||
                          ((prio_q[j] == win_prio_s) && (age_q[j] > win_age_s)));
            win_found_s = win_found_s | better_s;
            win_chan_s  = better_s ? CHANNEL_BIT'(j) : win_chan_s;
            win_prio_s  = better_s ? prio_q[j] : win_prio_s;
            win_age_s   = better_s ? age_q[j] : win_age_s;
        end
    end

    // Next priority/age/base: take-time aging first, then a config write overrides prio and base.
    always_comb begin
        for (int j = 0; j < CHANNEL; j++) begin
            prio_d[j] = prio_q[j];
            age_d[j]  = age_q[j];
            base_d[j] = base_q[j];
            if (take_s && (grant_chan_q == CHANNEL_BIT'(j))) begin
                prio_d[j] = base_q[j];
                age_d[j]  = 3'd0;
            end else if (take_s && bus.req[j]) begin
                if (age_q[j] == AGE_LIMIT_C) begin
                    age_d[j]  = 3'd0;
                    prio_d[j] = promote(prio_q[j]);
                end else begin
                    age_d[j]  = age_q[j] + 3'd1;
                end
            end else begin
                age_d[j] = age_q[j];
            end
            if (cfg_we_i && (cfg_chan_i == CHANNEL_BIT'(j))) begin
                base_d[j] = cfg_prio_i;
                prio_d[j] = cfg_prio_i;
            end else begin
                base_d[j] = base_q[j];
            end
        end
    end

    // Grant FSM plus priority state; grant_chan stays frozen for the whole offer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ARB;
            grant_valid_q <= 1'b0;
            grant_chan_q  <= '0;
            for (int j = 0; j < CHANNEL; j++) begin
                base_q[j] <= CHANNEL_PRIORITY[5*j +: 5];
                prio_q[j] <= CHANNEL_PRIORITY[5*j +: 5];
                age_q[j]  <= 3'd0;
            end
        end else begin
            base_q <= base_d;
            prio_q <= prio_d;
            age_q  <= age_d;
            case (state_q)
                ARB: begin
                    if (win_found_s) begin
                        grant_chan_q  <= win_chan_s;
                        grant_valid_q <= 1'b1;
                        state_q       <= OFFER;
                    end else begin
                        grant_valid_q <= 1'b0;
                        state_q       <= ARB;
                    end
                end
                OFFER: begin
                    if (bus.grant_take) begin
                        grant_valid_q <= 1'b0;
                        state_q       <= COOL;
                    end else if (!bus.req[grant_chan_q]) begin
                        grant_valid_q <= 1'b0;
                        state_q       <= ARB;
                    end else begin
                        grant_valid_q <= 1'b1;
                        state_q       <= OFFER;
                    end
                end
                COOL: begin
                    grant_valid_q <= 1'b0;
                    state_q       <= ARB;
                end
                default: begin
                    grant_valid_q <= 1'b0;
                    state_q       <= ARB;
                end
            endcase
        end
    end

    // Expose effective priorities straight from the registers.
    always_comb begin
        cur_prio_o = '0;
        for (int j = 0; j < CHANNEL; j++) begin
            cur_prio_o[5*j +: 5] = prio_q[j];
        end
    end
endmodule

// File: tb/tb_chan_send_arbiter.sv
// Bench for chan_send_arbiter: directed scenarios plus randomized traffic, all checked each cycle
// against a behavioural scheduling model.
module tb_chan_send_arbiter;
    localparam int              CB        = 1;
    localparam int              CH        = 2;
    localparam logic [5*CH-1:0] PRIO_INIT = {5'd4, 5'd9};
    localparam int              AGE_LIM   = 7;
    localparam int              PMAX      = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [CB-1:0]    cfg_chan;
    logic [4:0]       cfg_prio;
    logic [5*CH-1:0]  cur_prio;

    int errors = 0;
    int checks = 0;

    chan_send_arbiter_if #(.CHANNEL_BIT(CB)) bus ();

    chan_send_arbiter #(
        .CHANNEL_BIT      (CB),
        .CHANNEL_PRIORITY (PRIO_INIT),
        .AGE_LIMIT        (AGE_LIM),
        .PRIO_MAX         (PMAX)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .cfg_we_i   (cfg_we),
        .cfg_chan_i (cfg_chan),
        .cfg_prio_i (cfg_prio),
        .cur_prio_o (cur_prio)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_prio [CH];
    int m_base [CH];
    int m_age  [CH];
    int np [CH];
    int na [CH];
    int nb [CH];
    bit m_offer = 1'b0;
    bit m_cool  = 1'b0;
    int m_chan  = 0;
    bit model_ok = 1'b0;

    function automatic int init_prio(input int j);
        logic [5*CH-1:0] v;
        v = PRIO_INIT;
        return int'(v[5*j +: 5]);
    endfunction

    function automatic int pick(input logic [CH-1:0] r);
        int best;
        best = -1;
        for (int j = 0; j < CH; j++) begin
            if (r[j]) begin
                if (best < 0) best = j;
                else if (m_prio[j] > m_prio[best]) best = j;
                else if (m_prio[j] == m_prio[best] && m_age[j] > m_age[best]) best = j;
            end
        end
        return best;
    endfunction

    always @(posedge clk) begin : model
        if (rst) begin
            for (int j = 0; j < CH; j++) begin
                m_prio[j] <= init_prio(j);
                m_base[j] <= init_prio(j);
                m_age[j]  <= 0;
            end
            m_offer  <= 1'b0;
            m_cool   <= 1'b0;
            m_chan   <= 0;
            model_ok <= 1'b1;
        end else begin
            np = m_prio;
            na = m_age;
            nb = m_base;
            if (m_offer && bus.grant_take) begin
                for (int j = 0; j < CH; j++) begin
                    if (j == m_chan) begin
                        np[j] = m_base[j];
                        na[j] = 0;
                    end else if (bus.req[j]) begin
                        if (m_age[j] == AGE_LIM) begin
                            na[j] = 0;
                            np[j] = (m_prio[j] < PMAX) ? m_prio[j] + 1 : m_prio[j];
                        end else begin
                            na[j] = m_age[j] + 1;
                        end
                    end
                end
            end
            if (cfg_we) begin
                nb[int'(cfg_chan)] = int'(cfg_prio);
                np[int'(cfg_chan)] = int'(cfg_prio);
            end
            m_prio <= np;
            m_age  <= na;
            m_base <= nb;
            if (m_offer) begin
                if (bus.grant_take) begin
                    m_offer <= 1'b0;
                    m_cool  <= 1'b1;
                end else if (!bus.req[m_chan]) begin
                    m_offer <= 1'b0;
                end
            end else if (m_cool) begin
                m_cool <= 1'b0;
            end else if (bus.req != '0) begin
                m_chan  <= pick(bus.req);
                m_offer <= 1'b1;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            check("grant_valid", 32'(bus.grant_valid), 32'(m_offer));
            if (m_offer) check("grant_chan", 32'(bus.grant_chan), 32'(m_chan));
            for (int j = 0; j < CH; j++) begin
                check("cur_prio", 32'(cur_prio[5*j +: 5]), 32'(m_prio[j]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_valid(output int ok);
        int n;
        n = 0;
        while (!bus.grant_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 50) ? 1 : 0;
        if (ok == 0) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: got timeout expected grant_valid=1 at %0t", $time);
        end
    endtask

    task automatic take_one(output int ch);
        int ok;
        wait_valid(ok);
        if (ok != 0) begin
            ch = int'(bus.grant_chan);
            bus.grant_take = 1'b1;
            @(negedge clk);
            bus.grant_take = 1'b0;
        end else begin
            ch = -1;
        end
    endtask

    initial begin
        int ch;
        int ok;
        int n0;
        bit got1;

        rst = 1'b1;
        bus.req = '0;
        bus.grant_take = 1'b0;
        cfg_we = 1'b0;
        cfg_chan = '0;
        cfg_prio = 5'd0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus.grant_valid), 32'd0);
        check("rst_prio", 32'(cur_prio), 32'({5'd4, 5'd9}));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_valid", 32'(bus.grant_valid), 32'd0);

        // Aging: chan0 (9) beats chan1 (4) until chan1 is promoted to 9 and wins by age
        bus.req = 2'b11;
        @(negedge clk);
        check("latency_valid", 32'(bus.grant_valid), 32'd1);
        check("latency_chan", 32'(bus.grant_chan), 32'd0);
        n0 = 0;
        got1 = 1'b0;
        for (int k = 0; k < 60 && !got1; k++) begin
            take_one(ch);
            if (ch == 0) n0++;
            else got1 = 1'b1;
            if (k == 0) check("bubble_valid", 32'(bus.grant_valid), 32'd0);
            if (k == 7) check("promote_8", 32'(cur_prio[9:5]), 32'd5);
            if (k == 39) check("promote_40", 32'(cur_prio[9:5]), 32'd9);
        end
        check("chan0_grants", 32'(n0), 32'd41);
        check("chan1_base", 32'(cur_prio[9:5]), 32'd4);

        // Equal priority tie: lowest index first, then the aged channel
        rst = 1'b1;
        bus.req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        cfg_we = 1'b1; cfg_chan = 1'b0; cfg_prio = 5'd8;
        @(negedge clk);
        cfg_chan = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        bus.req = 2'b11;
        take_one(ch);
        check("tie_first", 32'(ch), 32'd0);
        take_one(ch);
        check("tie_age", 32'(ch), 32'd1);

        // Config raises chan1; withdraw its offer; then take+cfg on the same channel
        cfg_we = 1'b1; cfg_chan = 1'b1; cfg_prio = 5'd20;
        @(negedge clk);
        cfg_we = 1'b0;
        wait_valid(ok);
        check("cfg_wins", 32'(bus.grant_chan), 32'd1);
        bus.req = 2'b01;
        @(negedge clk);
        check("withdraw_valid", 32'(bus.grant_valid), 32'd0);
        check("withdraw_prio", 32'(cur_prio), 32'({5'd20, 5'd8}));
        @(negedge clk);
        check("rearb_valid", 32'(bus.grant_valid), 32'd1);
        check("rearb_chan", 32'(bus.grant_chan), 32'd0);
        take_one(ch);
        bus.req = 2'b11;
        wait_valid(ok);
        check("offer_chan1", 32'(bus.grant_chan), 32'd1);
        bus.grant_take = 1'b1;
        cfg_we = 1'b1; cfg_chan = 1'b1; cfg_prio = 5'd25;
        @(negedge clk);
        bus.grant_take = 1'b0;
        cfg_we = 1'b0;
        check("take_cfg_prio", 32'(cur_prio[9:5]), 32'd25);

        // Reset during an offer, with a simultaneous take
        wait_valid(ok);
        rst = 1'b1;
        bus.grant_take = 1'b1;
        @(negedge clk);
        check("rst_offer_valid", 32'(bus.grant_valid), 32'd0);
        check("rst_offer_prio", 32'(cur_prio), 32'({5'd4, 5'd9}));
        rst = 1'b0;
        bus.grant_take = 1'b0;

        // Randomized traffic, checked each cycle by the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.req        = ($urandom_range(0, 3) == 0) ? CH'($urandom) : 2'b11;
            bus.grant_take = ($urandom_range(0, 2) == 0);
            cfg_we         = ($urandom_range(0, 15) == 0);
            cfg_chan       = CB'($urandom);
            cfg_prio       = 5'($urandom_range(2, 17));
            if ($urandom_range(0, 99) == 0) cfg_prio = 5'($urandom_range(16, 31));
            rst            = ($urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.req = '0;
        bus.grant_take = 1'b0;
        cfg_we = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
